// File: rtl/imem_access_arbiter.sv
// imem_access_arbiter: shares the byte-wide instruction memory read port
// between the fetch (f_) and debug/loader (d_) requesters. Each grant reads
// four bytes and returns them as one big-endian 32-bit word. Out-of-range
// base addresses get an immediate error response with no memory traffic.
module imem_access_arbiter #(
  parameter int MEM_SIZE = 4095,
  parameter int MEM_AW   = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req,
  input  logic [63:0]       f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [31:0]       f_rdata,
  output logic              f_err,
  input  logic              d_req,
  input  logic [63:0]       d_addr,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic              mem_re,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [2:0] {IDLE, RD0, RD1, RD2, RD3, CAP, RESP} state_t;

  // Highest base address whose four bytes all lie inside the memory.
  localparam logic [MEM_AW-1:0] LAST_BASE = MEM_AW'(MEM_SIZE - 4);

  state_t            state_q, state_d;
  logic              rr_last_q, rr_last_d;   // 1: debug was granted last
  logic              owner_q, owner_d;       // 1: debug owns the transaction
  logic [MEM_AW-1:0] base_q, base_d;
  logic [23:0]       word_q, word_d;         // bytes 0..2 collected so far
  logic [31:0]       f_rdata_q, f_rdata_d, d_rdata_q, d_rdata_d;
  logic              f_err_q, f_err_d, d_err_q, d_err_d;

  logic              pick_d;                 // arbitration winner, 1: debug
  logic [63:0]       sel_addr;
  logic              addr_err;

  // Arbitration winner and range check of its address; only used in IDLE.
  always_comb begin
    pick_d   = (f_req && d_req) ? ~rr_last_q : d_req;
    sel_addr = pick_d ? d_addr : f_addr;
    addr_err = (|sel_addr[63:MEM_AW]) || (sel_addr[MEM_AW-1:0] > LAST_BASE);
  end

  // Next-state, read sequencing, byte assembly and response routing.
  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    owner_d   = owner_q;
    base_d    = base_q;
    word_d    = word_q;
    f_rdata_d = f_rdata_q;
    f_err_d   = f_err_q;
    d_rdata_d = d_rdata_q;
    d_err_d   = d_err_q;
    f_gnt     = 1'b0;
    d_gnt     = 1'b0;
    f_rvalid  = 1'b0;
    d_rvalid  = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = '0;
    case (state_q)
      IDLE: begin
        // A reset in the grant cycle cancels the grant outright.
        if ((f_req || d_req) && !reset) begin
          f_gnt     = ~pick_d;
          d_gnt     = pick_d;
          owner_d   = pick_d;
          rr_last_d = pick_d;
          base_d    = sel_addr[MEM_AW-1:0];
          if (addr_err) begin
            state_d = RESP;
            if (pick_d) begin
              d_rdata_d = '0;
              d_err_d   = 1'b1;
            end else begin
              f_rdata_d = '0;
              f_err_d   = 1'b1;
            end
          end else begin
            state_d = RD0;
          end
        end
      end
      RD0: begin
        mem_re   = 1'b1;
        mem_addr = base_q;
        state_d  = RD1;
      end
      RD1: begin
        mem_re          = 1'b1;
        mem_addr        = base_q + MEM_AW'(1);
        word_d[23:16]   = mem_rdata;
        state_d         = RD2;
      end
      RD2: begin
        mem_re          = 1'b1;
        mem_addr        = base_q + MEM_AW'(2);
        word_d[15:8]    = mem_rdata;
        state_d         = RD3;
      end
      RD3: begin
        mem_re          = 1'b1;
        mem_addr        = base_q + MEM_AW'(3);
        word_d[7:0]     = mem_rdata;
        state_d         = CAP;
      end
      CAP: begin
        // Last byte lands directly in the owner's response register.
        if (owner_q) begin
          d_rdata_d = {word_q, mem_rdata};
          d_err_d   = 1'b0;
        end else begin
          f_rdata_d = {word_q, mem_rdata};
          f_err_d   = 1'b0;
        end
        state_d = RESP;
      end
      RESP: begin
        f_rvalid = ~owner_q;
        d_rvalid = owner_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign f_rdata = f_rdata_q;
  assign f_err   = f_err_q;
  assign d_rdata = d_rdata_q;
  assign d_err   = d_err_q;

  // State register; reset drops any in-flight transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      rr_last_q <= 1'b1;
      owner_q   <= 1'b0;
      base_q    <= '0;
      word_q    <= '0;
      f_rdata_q <= '0;
      f_err_q   <= 1'b0;
      d_rdata_q <= '0;
      d_err_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      owner_q   <= owner_d;
      base_q    <= base_d;
      word_q    <= word_d;
      f_rdata_q <= f_rdata_d;
      f_err_q   <= f_err_d;
      d_rdata_q <= d_rdata_d;
      d_err_q   <= d_err_d;
    end
  end

endmodule

// File: tb/tb_imem_access_arbiter.sv
// Scoreboard bench for imem_access_arbiter: stimulus pushes expected
// responses at grant time; a negedge monitor pops and compares them.
module tb_imem_access_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        f_req, d_req;
  logic [63:0] f_addr, d_addr;
  logic        f_gnt, f_rvalid, f_err, d_gnt, d_rvalid, d_err;
  logic [31:0] f_rdata, d_rdata;
  logic        mem_re;
  logic [11:0] mem_addr;
  logic [7:0]  mem_rdata;

  logic [7:0]  mem [0:4095];

  typedef struct {
    bit          port;
    logic [31:0] data;
    bit          err;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  imem_access_arbiter #(.MEM_SIZE(4095), .MEM_AW(12)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
    .f_rdata(f_rdata), .f_err(f_err),
    .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .d_rdata(d_rdata), .d_err(d_err),
    .mem_re(mem_re), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous memory: data the cycle after mem_re, filler otherwise.
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= mem[mem_addr];
    else        mem_rdata <= 8'hA5;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Response monitor.
  always @(negedge clk) begin
    exp_t e;
    if (f_rvalid || d_rvalid) begin
      chk("rvalid_both_ports", {63'd0, f_rvalid & d_rvalid}, 64'd0);
      if (sb.size() == 0) begin
        chk("unexpected_rvalid", {62'd0, d_rvalid, f_rvalid}, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("resp_port", {63'd0, d_rvalid}, {63'd0, e.port});
        chk("resp_rdata", {32'd0, e.port ? d_rdata : f_rdata}, {32'd0, e.data});
        chk("resp_err", {63'd0, e.port ? d_err : f_err}, {63'd0, e.err});
      end
    end
  end

  task automatic start(input bit port, input logic [63:0] addr);
    @(posedge clk); #1;
    if (port) begin d_req = 1'b1; d_addr = addr; end
    else      begin f_req = 1'b1; f_addr = addr; end
  endtask

  task automatic drop();
    @(posedge clk); #1;
    f_req = 1'b0;
    d_req = 1'b0;
  endtask

  task automatic wait_gnt(input bit port, output bit ok);
    int n;
    n  = 0;
    ok = 1'b0;
    @(negedge clk);
    while (!ok && n < 40) begin
      if (port ? d_gnt : f_gnt) ok = 1'b1;
      else begin @(negedge clk); n++; end
    end
    chk("gnt_wait", {63'd0, ok}, 64'd1);
  endtask

  // Checks T+1..T+6 of a good read; entered just after the edge into T+1.
  task automatic follow(input bit port, input logic [11:0] base);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("mem_re_rd", {63'd0, mem_re}, 64'd1);
      chk("mem_addr_rd", {52'd0, mem_addr}, {52'd0, base + 12'(k)});
    end
    @(negedge clk);
    chk("mem_re_cap", {63'd0, mem_re}, 64'd0);
    @(negedge clk);
    chk("rvalid_t6", {62'd0, d_rvalid, f_rvalid}, port ? 64'd2 : 64'd1);
  endtask

  task automatic read_ok(input bit port, input logic [63:0] addr, input logic [31:0] data);
    bit ok;
    start(port, addr);
    wait_gnt(port, ok);
    if (ok) sb.push_back('{port, data, 1'b0});
    drop();
    if (ok) follow(port, addr[11:0]);
  endtask

  task automatic read_err(input bit port, input logic [63:0] addr);
    bit ok;
    start(port, addr);
    wait_gnt(port, ok);
    if (ok) sb.push_back('{port, 32'd0, 1'b1});
    drop();
    @(negedge clk);
    chk("err_rvalid_t1", {62'd0, d_rvalid, f_rvalid}, port ? 64'd2 : 64'd1);
    chk("err_no_mem_re_t1", {63'd0, mem_re}, 64'd0);
    @(negedge clk);
    chk("err_no_mem_re_t2", {63'd0, mem_re}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int cyc, got, last;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[0] = 8'h00; mem[1] = 8'h50; mem[2] = 8'h00; mem[3] = 8'h93;
    mem[5] = 8'hDE; mem[6] = 8'hAD; mem[7] = 8'hBE; mem[8] = 8'hEF;
    mem[4091] = 8'h11; mem[4092] = 8'h22; mem[4093] = 8'h33; mem[4094] = 8'h44;
    reset = 1'b1; f_req = 1'b0; d_req = 1'b0; f_addr = '0; d_addr = '0;
    repeat (2) @(negedge clk);
    chk("reset_outputs",
        {f_gnt, f_rvalid, f_err, d_gnt, d_rvalid, d_err, mem_re, 57'd0},
        64'd0);
    chk("reset_rdata", {f_rdata, d_rdata}, 64'd0);
    chk("reset_mem_addr", {52'd0, mem_addr}, 64'd0);
    @(posedge clk); #1 reset = 1'b0;

    // Basic, unaligned and boundary reads.
    read_ok(1'b0, 64'd0, 32'h00500093);
    read_ok(1'b1, 64'd5, 32'hDEADBEEF);
    read_ok(1'b0, 64'd4091, 32'h11223344);
    read_err(1'b0, 64'd4092);
    read_err(1'b1, 64'h1_0000_0000);

    // Both ports requesting from reset: strict alternation every 7 cycles.
    @(posedge clk); #1;
    reset = 1'b1; f_req = 1'b1; f_addr = 64'd0; d_req = 1'b1; d_addr = 64'd5;
    @(negedge clk);
    chk("gnt_masked_in_reset", {62'd0, d_gnt, f_gnt}, 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    cyc = 0; got = 0; last = -1;
    while (got < 4 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (f_gnt || d_gnt) begin
        chk("arb_single_gnt", {63'd0, f_gnt & d_gnt}, 64'd0);
        chk("arb_order", {63'd0, d_gnt}, 64'(got % 2));
        sb.push_back('{d_gnt, d_gnt ? 32'hDEADBEEF : 32'h00500093, 1'b0});
        if (last >= 0) chk("arb_gap", 64'(cyc - last), 64'd7);
        last = cyc;
        got++;
        if (got == 4) drop();
      end
    end
    chk("arb_grants", 64'(got), 64'd4);
    repeat (8) @(negedge clk);
    chk("arb_sb_drained", 64'(sb.size()), 64'd0);

    // Reset in T+3 of a fetch: response is dropped.
    start(1'b0, 64'd0);
    wait_gnt(1'b0, ok);
    drop();
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("mid_reset_mem_re_before", {63'd0, mem_re}, 64'd1);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("mid_reset_mem_re_after", {63'd0, mem_re}, 64'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("mid_reset_no_rvalid", {62'd0, d_rvalid, f_rvalid}, 64'd0);
    end
    read_ok(1'b0, 64'd5, 32'hDEADBEEF);

    // Debug request pulsed only during the fetch's RD1 cycle.
    start(1'b0, 64'd0);
    wait_gnt(1'b0, ok);
    if (ok) sb.push_back('{1'b0, 32'h00500093, 1'b0});
    drop();
    fork
      follow(1'b0, 12'd0);
      begin
        @(posedge clk); #1;
        d_req = 1'b1; d_addr = 64'd8;
        @(negedge clk);
        chk("withdraw_no_gnt_rd1", {63'd0, d_gnt}, 64'd0);
        @(posedge clk); #1 d_req = 1'b0;
      end
    join
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("withdraw_no_d_activity", {62'd0, d_gnt, d_rvalid}, 64'd0);
    end

    chk("sb_empty_at_end", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
